mul_sgn_trunc_pipe: RTL and testbench
=====================================

// Module: mul_sgn_trunc_pipe
// PURPOSE
//   Parametrised signed (two's-complement) WIDTH x WIDTH approximate multiplier with column truncation.
//   Pipelined, with a valid/ready handshake and a per-transaction exact/approximate mode bit.
//   Successor to the fixed 8x8 truncated Baugh-Wooley array; drop-in operator for accelerator datapaths.
// PARAMETERS
//   WIDTH        8  operand width in bits (>=4)
//   TRUNC        5  partial-product columns dropped (0..WIDTH-1); 0 = exact
//   PIPE_STAGES  2  register stages, input to output (>=1)
// PORTS
//   clock      in   1        single clock, all state on rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        operand beat valid
//   in_ready   out  1        block accepts a beat this cycle
//   a          in   WIDTH    signed multiplicand
//   b          in   WIDTH    signed multiplier
//   exact      in   1        1 = full product for this beat; 0 = truncated
//   out_valid  out  1        result beat valid
//   out_ready  in   1        downstream accepts result
//   o          out  2*WIDTH  signed product (mod 2^(2*WIDTH))
// BEHAVIOUR
//   - One clock; reset synchronous active-high. On reset all stage-valid bits clear: out_valid=0, o=0.
//     in_ready=1 from the first cycle after reset. In-flight beats are discarded.
//   - Global enable en = ~out_valid | out_ready; in_ready = en. All stages shift together when en=1.
//     Bubbles are not collapsed; when en=0 every stage holds.
//   - Beat accepted when in_valid & in_ready. Its result appears PIPE_STAGES cycles later if never stalled.
//     Order is preserved; no beat is lost or duplicated under any out_ready pattern.
//   - out_valid/o stay stable while out_valid & ~out_ready.
//   - Arithmetic (golden model): pp(i,j) = a[i]&b[j], weight 2^(i+j).
//     Weight is negated when exactly one of i,j equals WIDTH-1 (Baugh-Wooley).
//     exact=1: o = sum of all terms = a*b mod 2^(2*WIDTH).
//     exact=0: o = sum of terms with i+j >= TRUNC only, so o[TRUNC-1:0] = 0 always.
//   - The exact bit travels with its beat; mixed modes back-to-back are legal.
//   - TRUNC=0: both modes identical. No overflow possible: -2^(2W-2) <= a*b <= 2^(2W-2).
// CONFIGURATION
//   Macro MUL_SGN_TRUNC_COMP_EN:
//   - Defined: truncated beats (exact=0, TRUNC>=1) add constant bias K.
//     K = ((((TRUNC-1)<<TRUNC)+1+(1<<(TRUNC+1))) >> (TRUNC+2)) << TRUNC, i.e. E[dropped sum] rounded to a
//     multiple of 2^TRUNC (K=32 for TRUNC=5). Sum taken mod 2^(2*WIDTH). Exact beats are unaffected.
//   - Undefined: no bias adder is present; exact=0 results are the plain truncated sum.
// STRUCTURE
//   - Package mul_sgn_trunc_pkg: function comp_k(TRUNC); localparam PW = 2*WIDTH helper;
//     typedef of the stage record {valid, exact, a, b / partial sum}.
//   - Sub-module mul_sgn_trunc_core: combinational. Generates the partial-product array with column
//     mask (i+j >= TRUNC when ~exact), plus optional K. Carry-save rows, final CPA.
//   - Stage 1 registers operands and mode. Stages 2..PIPE_STAGES retime the core result.
//     With PIPE_STAGES=1, o is the registered core output of the stage-1 record.
// TESTING  (WIDTH=8, TRUNC=5, PIPE_STAGES=2, out_ready=1 unless stated)
//   1. a=7, b=3, exact=0 -> o=0x0000 (0x0020 with COMP_EN); exact=1 -> o=0x0015, 2 cycles after accept.
//   2. a=127, b=127: exact=1 -> 0x3F01; exact=0 -> 0x3E80 (16000); COMP_EN -> 0x3EA0.
//   3. a=-1, b=-1: exact=1 -> 0x0001; exact=0 -> 0xFF80 (-128). a=-128, b=-128 -> 0x4000 in both modes.
//   4. Stream 6 beats, out_ready=0 for 3 cycles mid-stream:
//      -> in_ready=0 while out_valid & ~out_ready; o held; all 6 results in order, none dropped.
//   5. reset=1 for 1 cycle with 2 beats in flight:
//      -> out_valid=0 next cycle; no stale result emitted; a new beat completes with normal latency.
//   6. 10k random a/b/exact plus random out_ready -> scoreboard vs golden model; low 5 bits zero on every exact=0 beat.

Source files
------------

// File: rtl/mul_sgn_trunc_pkg.sv
// Shared helpers for the truncated signed multiplier: product width, truncation bias, stage record.
package mul_sgn_trunc_pkg;

    function automatic int prod_width(int width);
        return 2 * width;
    endfunction

    // Expected value of the dropped columns, rounded to a multiple of 2^trunc.
    function automatic int comp_k(int trunc);
        if (trunc < 1) return 0;
        return ((((trunc - 1) << trunc) + 1 + (1 << (trunc + 1))) >> (trunc + 2)) << trunc;
    endfunction

    typedef struct packed {
        logic valid;
        logic exact;
    } stage_ctl_t;

endpackage

// File: rtl/mul_sgn_trunc_core.sv
// Combinational Baugh-Wooley partial-product array with optional column truncation.
// MUL_SGN_TRUNC_COMP_EN adds the constant truncation bias to approximate products.
module mul_sgn_trunc_core
    import mul_sgn_trunc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 5
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               exact,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = prod_width(WIDTH);

    logic [PW-1:0] pos_row;
    logic [PW-1:0] neg_row;
    logic [PW-1:0] pos_sum;
    logic [PW-1:0] neg_sum;
    logic [PW-1:0] bias;

`ifdef MUL_SGN_TRUNC_COMP_EN
    localparam logic [PW-1:0] K = PW'(comp_k(TRUNC));
    assign bias = (!exact && TRUNC >= 1) ? K : '0;
`else
    assign bias = '0;
`endif

    // Terms with exactly one sign bit carry negative weight; they accumulate separately.
    always_comb begin
        pos_row = '0;
        neg_row = '0;
        pos_sum = '0;
        neg_sum = '0;
        for (int j = 0; j < WIDTH; j++) begin
            pos_row = '0;
            neg_row = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if ((exact || (i + j) >= TRUNC) && a[i] && b[j]) begin
                    if ((i == WIDTH - 1) != (j == WIDTH - 1))
                        neg_row[i + j] = 1'b1;
                    else
                        pos_row[i + j] = 1'b1;
                end
            end
            pos_sum = pos_sum + pos_row;
            neg_sum = neg_sum + neg_row;
        end
        p = pos_sum - neg_sum + bias;
    end

endmodule

// File: rtl/mul_sgn_trunc_pipe.sv
// Pipelined signed WIDTH x WIDTH truncated multiplier with valid/ready flow control.
// MUL_SGN_TRUNC_COMP_EN (see core) enables the truncation bias on approximate beats.
module mul_sgn_trunc_pipe
    import mul_sgn_trunc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TRUNC       = 5,
    parameter int PIPE_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o
);

    localparam int PW = prod_width(WIDTH);

    stage_ctl_t       s1_ctl;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [PW-1:0]    core_p;
    logic             en;

    // Whole pipe advances in lockstep; bubbles are not squeezed out.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // exact resets high so a reset stage-1 record yields a zero product even with bias enabled.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_ctl.valid <= 1'b0;
            s1_ctl.exact <= 1'b1;
            s1_a         <= '0;
            s1_b         <= '0;
        end else if (en) begin
            s1_ctl.valid <= in_valid;
            s1_ctl.exact <= exact;
            s1_a         <= a;
            s1_b         <= b;
        end
    end

    mul_sgn_trunc_core #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .exact (s1_ctl.exact),
        .p     (core_p)
    );

    generate
        if (PIPE_STAGES == 1) begin : g_one
            assign out_valid = s1_ctl.valid;
            assign o         = core_p;
        end else begin : g_multi
            localparam int NR = PIPE_STAGES - 1;

            logic [NR-1:0] vld;
            logic [PW-1:0] dat [NR];

            always_ff @(posedge clock) begin
                if (reset) begin
                    vld <= '0;
                    for (int k = 0; k < NR; k++) dat[k] <= '0;
                end else if (en) begin
                    vld[0] <= s1_ctl.valid;
                    dat[0] <= core_p;
                    for (int k = 1; k < NR; k++) begin
                        vld[k] <= vld[k-1];
                        dat[k] <= dat[k-1];
                    end
                end
            end

            assign out_valid = vld[NR-1];
            assign o         = dat[NR-1];
        end
    endgenerate

endmodule

// File: tb/tb_mul_sgn_trunc_pipe.sv
// Directed and random checks for mul_sgn_trunc_pipe at WIDTH=8, TRUNC=5, PIPE_STAGES=2.
module tb_mul_sgn_trunc_pipe;

`ifdef MUL_SGN_TRUNC_COMP_EN
    localparam logic [15:0] KB = 16'h0020;
`else
    localparam logic [15:0] KB = 16'h0000;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        exact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q [$];
    logic        ex_q  [$];

    // Directed vectors; dv_exp is the unbiased result, KB is added on approximate beats.
    logic [7:0]  dv_a   [9] = '{8'd7, 8'd7, 8'd127, 8'd127, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80};
    logic [7:0]  dv_b   [9] = '{8'd3, 8'd3, 8'd127, 8'd127, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h7F};
    logic        dv_ex  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] dv_exp [9] = '{16'h0000, 16'h0015, 16'h3F01, 16'h3E80, 16'h0001,
                                16'hFF80, 16'h4000, 16'h4000, 16'hC080};

    logic [7:0]  sa [6] = '{8'd5, 8'hFD, 8'd100, 8'h9C, 8'd64, 8'hC8};
    logic [7:0]  sb [6] = '{8'hF9, 8'd9, 8'd100, 8'd77, 8'h80, 8'hE0};
    logic        sx [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clock = ~clock;

    mul_sgn_trunc_pipe #(
        .WIDTH       (8),
        .TRUNC       (5),
        .PIPE_STAGES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .exact     (exact),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    // Reference: true product minus the dropped low columns (all positive-weight when TRUNC < WIDTH).
    function automatic logic [15:0] model(logic [7:0] x, logic [7:0] y, logic ex);
        int prod;
        int dropped;
        prod    = $signed(x) * $signed(y);
        dropped = 0;
        if (!ex) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    if ((i + j) < 5 && x[i] && y[j]) dropped += (1 << (i + j));
            prod = prod - dropped + int'(KB);
        end
        return prod[15:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; exact = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #4;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (o !== 16'h0000) begin failures++; $display("FAIL reset_o got=%h want=0000", o); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        tick();
    endtask

    task automatic test_directed();
        logic [15:0] e;
        for (int v = 0; v < 9; v++) begin
            e = dv_ex[v] ? dv_exp[v] : dv_exp[v] + KB;
            in_valid = 1'b1; a = dv_a[v]; b = dv_b[v]; exact = dv_ex[v];
            #4;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b want=1", v, in_ready); end
            tick();
            in_valid = 1'b0;
            #4;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early got=%b want=0", v, out_valid); end
            tick();
            #4;
            checks++;
            if (out_valid !== 1'b1 || o !== e) begin
                failures++;
                $display("FAIL dir%0d_result got=%b/%h want=1/%h", v, out_valid, o, e);
            end
            tick();
            #4;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_dup got=%b want=0", v, out_valid); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int c = 0; c < 11; c++) begin
            in_valid = (c < 9);
            if (c < 9) begin a = dv_a[c]; b = dv_b[c]; exact = dv_ex[c]; end
            #4;
            if (c >= 2) begin
                e = dv_ex[c-2] ? dv_exp[c-2] : dv_exp[c-2] + KB;
                checks++;
                if (out_valid !== 1'b1 || o !== e) begin
                    failures++;
                    $display("FAIL b2b%0d got=%b/%h want=1/%h", c - 2, out_valid, o, e);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #4;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_tail got=%b want=0", out_valid); end
        tick();
    endtask

    task automatic test_stall();
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_o = '0;
        logic [15:0] e;
        exp_q.delete();
        while (rcvd < 6 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 6);
            if (sent < 6) begin a = sa[sent]; b = sb[sent]; exact = sx[sent]; end
            #4;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || o !== prev_o) begin
                    failures++;
                    $display("FAIL stall_hold got=%b/%h want=1/%h", out_valid, o, prev_o);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stall_extra got=%h want=none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin failures++; $display("FAIL stall_beat%0d got=%h want=%h", rcvd, o, e); end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, exact));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = o;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != 6) begin failures++; $display("FAIL stall_count got=%0d want=6", rcvd); end
    endtask

    task automatic test_reset_inflight();
        in_valid = 1'b1; a = 8'd9; b = 8'd9; exact = 1'b1; out_ready = 1'b1;
        tick();
        a = 8'd11; b = 8'd13;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #4;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale%0d got=%b want=0", c, out_valid); end
            tick();
        end
        in_valid = 1'b1; a = 8'd7; b = 8'd3; exact = 1'b1;
        #4;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        #4;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_early got=%b want=0", out_valid); end
        tick();
        #4;
        checks++;
        if (out_valid !== 1'b1 || o !== 16'h0015) begin
            failures++;
            $display("FAIL rst_new got=%b/%h want=1/0015", out_valid, o);
        end
        tick();
    endtask

    task automatic test_random();
        int          sent = 0;
        int          rcvd = 0;
        int          cyc  = 0;
        logic        prev_stall = 1'b0;
        logic [15:0] prev_o = '0;
        logic [15:0] e;
        logic        ex;
        exp_q.delete();
        ex_q.delete();
        while (rcvd < 10000 && cyc < 60000) begin
            in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(9) < 7);
            a         = 8'($urandom_range(255));
            b         = 8'($urandom_range(255));
            exact     = 1'($urandom_range(1));
            #4;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || o !== prev_o) begin
                    failures++;
                    $display("FAIL rnd_hold got=%b/%h want=1/%h", out_valid, o, prev_o);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got=%h want=none", o);
                end else begin
                    e  = exp_q.pop_front();
                    ex = ex_q.pop_front();
                    if (o !== e) begin failures++; $display("FAIL rnd_beat%0d got=%h want=%h", rcvd, o, e); end
                    if (!ex) begin
                        checks++;
                        if (o[4:0] !== 5'd0) begin failures++; $display("FAIL rnd_lowbits got=%h want=00", o[4:0]); end
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, exact));
                ex_q.push_back(exact);
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = o;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcvd != 10000) begin failures++; $display("FAIL rnd_count got=%0d want=10000", rcvd); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
